// File: rtl/sbus_pkg.sv
// Shared types and helpers for the round-robin serial bus transmitter.
// SBUS_CRC_EN adds the CRC-4 field to the frame.
package sbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SRC,
    ST_DST,
    ST_DATA,
`ifdef SBUS_CRC_EN
    ST_CRC,
`endif
    ST_STOP
  } sbus_state_e;

  localparam logic [3:0] CRC_POLY = 4'h3;
  localparam logic [3:0] CRC_INIT = 4'h0;

  function automatic int unsigned frame_len(input int unsigned addr_w,
                                            input int unsigned data_w);
`ifdef SBUS_CRC_EN
    return 2 * addr_w + data_w + 6;
`else
    return 2 * addr_w + data_w + 2;
`endif
  endfunction

  // One serial step of x^4+x+1 over a transmitted bit.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic b);
    logic fb;
    fb = crc[3] ^ b;
    return {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'h0);
  endfunction

endpackage

// File: rtl/sbus_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i,
// wrapping at N_CH. The pointer register lives in the parent.
module sbus_rr_arbiter #(
  parameter int unsigned N_CH = 16,
  parameter int unsigned PW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [PW-1:0]   grant_o,
  output logic            grant_valid_o
);

  logic [2*N_CH-1:0] req2;
  logic [N_CH-1:0]   rot;
  logic [PW:0]       sum;
  logic              found;

  always_comb begin
    req2          = {req_i, req_i} >> ptr_i;
    rot           = req2[N_CH-1:0];
    sum           = '0;
    found         = 1'b0;
    grant_o       = '0;
    grant_valid_o = 1'b0;
    // rot[i] is channel ptr_i+i; the lowest set bit wins.
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (en_i && !found && rot[i]) begin
        sum = {1'b0, ptr_i} + (PW+1)'(i);
        if (sum >= (PW+1)'(N_CH)) begin
          sum = sum - (PW+1)'(N_CH);
        end
        grant_o       = sum[PW-1:0];
        grant_valid_o = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sbus_rr_transmitter.sv
// Round-robin serial bus transmitter: arbitrates N_CH channels and serialises
// start, src, dst, payload, [CRC-4 when SBUS_CRC_EN is defined] and stop bits.
module sbus_rr_transmitter
  import sbus_pkg::*;
#(
  parameter int unsigned N_CH   = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*ADDR_W-1:0]   dst_addr,
  input  logic [N_CH*DATA_W-1:0]   data,
  output logic [N_CH-1:0]          ack,
  output logic                     bus_show,
  output logic                     busy
);

  localparam int unsigned PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW = $clog2(DATA_W) + 1;
  localparam int unsigned SW = 2 * ADDR_W + DATA_W;

  if ((N_CH < 1) || (N_CH > (2 ** ADDR_W)) || (DATA_W < 2) || (ADDR_W > DATA_W)) begin : g_cfg_err
    $error("sbus_rr_transmitter: N_CH must be in 1..2**ADDR_W, DATA_W >= 2, ADDR_W <= DATA_W");
  end

  sbus_state_e       state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     sh_q, sh_d;
`ifdef SBUS_CRC_EN
  logic [3:0]        crc_q, crc_d;
`endif

  logic [PW-1:0]     arb_grant;
  logic              arb_valid;
  logic [ADDR_W-1:0] sel_dst;
  logic [DATA_W-1:0] sel_data;

  sbus_rr_arbiter #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_arb (
    .req_i         (req),
    .ptr_i         (ptr_q),
    .en_i          (state_q == ST_IDLE),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  always_comb begin
    sel_dst  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (arb_grant == PW'(i)) begin
        sel_dst  = dst_addr[i*ADDR_W +: ADDR_W];
        sel_data = data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
`ifdef SBUS_CRC_EN
      crc_q   <= CRC_INIT;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
`ifdef SBUS_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
`ifdef SBUS_CRC_EN
    crc_d    = crc_q;
`endif
    bus_show = 1'b1;
    busy     = 1'b1;
    ack      = '0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (arb_valid) begin
          grant_d = arb_grant;
          sh_d    = {ADDR_W'(arb_grant), sel_dst, sel_data};
`ifdef SBUS_CRC_EN
          crc_d   = CRC_INIT;
`endif
          ptr_d   = (arb_grant == PW'(N_CH - 1)) ? '0 : arb_grant + 1'b1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        bus_show = 1'b0;
        cnt_d    = CW'(ADDR_W - 1);
        state_d  = ST_SRC;
      end

      // src, dst and payload are one contiguous shift register.
      ST_SRC, ST_DST, ST_DATA: begin
        bus_show = sh_q[SW-1];
        sh_d     = {sh_q[SW-2:0], 1'b0};
`ifdef SBUS_CRC_EN
        crc_d    = crc4_step(crc_q, sh_q[SW-1]);
`endif
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case (state_q)
            ST_SRC: begin
              cnt_d   = CW'(ADDR_W - 1);
              state_d = ST_DST;
            end
            ST_DST: begin
              cnt_d   = CW'(DATA_W - 1);
              state_d = ST_DATA;
            end
            default: begin
`ifdef SBUS_CRC_EN
              cnt_d   = CW'(3);
              state_d = ST_CRC;
`else
              state_d = ST_STOP;
`endif
            end
          endcase
        end
      end

`ifdef SBUS_CRC_EN
      ST_CRC: begin
        bus_show = crc_q[3];
        crc_d    = {crc_q[2:0], 1'b0};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        bus_show = 1'b1;
        for (int unsigned i = 0; i < N_CH; i++) begin
          ack[i] = (grant_q == PW'(i));
        end
        state_d = ST_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sbus_rr_transmitter.sv
// Scoreboard bench for sbus_rr_transmitter: expected frames are queued when
// requests are raised and compared bit-for-bit as frames leave bus_show.
module tb_sbus_rr_transmitter;

  localparam int N_CH   = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;
`ifdef SBUS_CRC_EN
  localparam int FLEN = 2 * ADDR_W + DATA_W + 6;
`else
  localparam int FLEN = 2 * ADDR_W + DATA_W + 2;
`endif

  logic                   clock;
  logic                   reset_n;
  logic [N_CH-1:0]        req;
  logic [N_CH*ADDR_W-1:0] dst_addr;
  logic [N_CH*DATA_W-1:0] data;
  logic [N_CH-1:0]        ack;
  logic                   bus_show;
  logic                   busy;

  sbus_rr_transmitter #(
    .N_CH   (N_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .dst_addr (dst_addr),
    .data     (data),
    .ack      (ack),
    .bus_show (bus_show),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          ch;
    logic [3:0]  dst;
    logic [63:0] dat;
    int          gap;   // required idle cycles before this frame, -1 = any
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bit              in_frame = 1'b0;
  int              nbits    = 0;
  int              ack_pos  = 0;
  int              ack_hits = 0;
  int              idle_cnt = 0;
  int              gap      = 0;
  logic [127:0]    obs      = '0;
  logic [N_CH-1:0] ack_val  = '0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] model_frame(input exp_t e);
    logic [71:0]  m;
    logic [3:0]   c;
    logic         fb;
    logic [127:0] f;
    m = {4'(e.ch), e.dst, e.dat};
    c = 4'h0;
    for (int i = 71; i >= 0; i--) begin
      fb = c[3] ^ m[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
`ifdef SBUS_CRC_EN
    f = {50'b0, 1'b0, m, c, 1'b1};
`else
    f = {54'b0, 1'b0, m, 1'b1};
`endif
    return f;
  endfunction

  task automatic end_frame();
    exp_t            e;
    logic [N_CH-1:0] onehot;
    if (sb.size() == 0) begin
      check("unexpected_frame", 1, 0);
    end else begin
      e = sb.pop_front();
      onehot = N_CH'(1) << e.ch;
      check("frame_len", nbits, FLEN);
      check("frame_bits", obs, model_frame(e));
      check("ack_chan", ack_val, onehot);
      check("ack_pos", ack_pos, FLEN);
      check("ack_count", ack_hits, 1);
      if (e.gap >= 0) check("idle_gap", gap, e.gap);
      if (e.ch == 1 && e.dst == 4'd2 && e.dat == 64'h1) begin
`ifdef SBUS_CRC_EN
        check("crc_example", obs[4:1], 4'b0110);
`else
        check("stop_after_d0", obs[1:0], 2'b11);
`endif
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      if (in_frame) check("abort_no_ack", ack_hits, 0);
      in_frame = 1'b0;
      idle_cnt = 0;
    end else if (busy) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        nbits    = 0;
        obs      = '0;
        ack_pos  = 0;
        ack_hits = 0;
        ack_val  = '0;
        gap      = idle_cnt;
      end
      obs = {obs[126:0], bus_show};
      nbits++;
      if (ack != '0) begin
        ack_hits++;
        ack_pos = nbits;
        ack_val = ack;
      end
    end else begin
      if (ack != '0) check("ack_idle", ack, 0);
      if (bus_show !== 1'b1) check("idle_line", bus_show, 1);
      if (in_frame) begin
        in_frame = 1'b0;
        end_frame();
        idle_cnt = 1;
      end else begin
        idle_cnt++;
      end
    end
  end

  task automatic set_chan(input int ch, input logic [3:0] d, input logic [63:0] v);
    logic [N_CH*DATA_W-1:0] dm;
    logic [N_CH*ADDR_W-1:0] am;
    dm       = {{((N_CH-1)*DATA_W){1'b0}}, {DATA_W{1'b1}}} << (ch * DATA_W);
    am       = {{((N_CH-1)*ADDR_W){1'b0}}, {ADDR_W{1'b1}}} << (ch * ADDR_W);
    data     = (data & ~dm) | ((N_CH*DATA_W)'(v) << (ch * DATA_W));
    dst_addr = (dst_addr & ~am) | ((N_CH*ADDR_W)'(d) << (ch * ADDR_W));
  endtask

  task automatic post(input int ch, input logic [3:0] d, input logic [63:0] v, input int g);
    exp_t e;
    set_chan(ch, d, v);
    e.ch  = ch;
    e.dst = d;
    e.dat = v;
    e.gap = g;
    sb.push_back(e);
    req = req | (N_CH'(1) << ch);
  endtask

  task automatic wait_busy(input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      #1;
      lat++;
    end while (!busy && lat < budget);
    if (!busy) check("busy_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clock);
      #1;
      req = req & ~ack;
      n++;
    end
    if (n >= budget) begin
      check("drain_timeout", 1, 0);
      sb.delete();
      req = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ch;
    reset_n  = 1'b0;
    req      = '1;
    dst_addr = '0;
    data     = '0;

    repeat (4) begin
      @(negedge clock);
      #1;
      check("rst_bus_show", bus_show, 1);
      check("rst_busy", busy, 0);
      check("rst_ack", ack, 0);
    end
    req = '0;
    @(negedge clock);
    reset_n = 1'b1;

    // Pointer starts at 0: simultaneous 0,1,2 served in order, one idle bit apart.
    post(0, 4'hA, 64'h0123_4567_89AB_CDEF, -1);
    post(1, 4'h5, 64'hFFFF_0000_FFFF_0000, 1);
    post(2, 4'h2, 64'h8000_0000_0000_0001, 1);
    drain(600);

    // Reference frame; inputs changed after grant must not affect it.
    post(1, 4'd2, 64'h1, -1);
    wait_busy(10, lat);
    check("grant_latency", lat, 1);
    set_chan(1, 4'hF, 64'hDEAD_BEEF_DEAD_BEEF);
    drain(300);

    // ch2 served -> pointer 3; then 1 and 3 together -> 3 first.
    post(2, 4'h7, 64'h0F0F_0F0F_0F0F_0F0F, -1);
    drain(300);
    post(3, 4'h3, 64'hAAAA_5555_AAAA_5555, -1);
    post(1, 4'h1, 64'h1357_9BDF_2468_ACE0, 1);
    drain(600);

    // Pointer now 2: ch15 then wrap to ch0.
    post(15, 4'hE, 64'hFEDC_BA98_7654_3210, -1);
    post(0, 4'h0, 64'h0000_0000_0000_0000, 1);
    drain(600);

    for (int k = 0; k < 6; k++) begin
      ch = int'($urandom_range(0, N_CH - 1));
      post(ch, 4'($urandom), {$urandom, $urandom}, -1);
      drain(300);
    end

    // Abort a frame from ch7 inside its payload.
    set_chan(7, 4'h9, 64'hC3C3_C3C3_C3C3_C3C3);
    req[7] = 1'b1;
    wait_busy(10, lat);
    repeat (19) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_bus_show", bus_show, 1);
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    req = '0;
    repeat (2) @(negedge clock);
    #1;
    reset_n = 1'b1;

    // Pointer back at 0: ch5 beats ch9.
    post(5, 4'h6, 64'h5555_AAAA_5555_AAAA, -1);
    post(9, 4'hB, 64'h0000_FFFF_0000_FFFF, 1);
    drain(600);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sbus_rr_transmitter.md
Name: sbus_rr_transmitter

Overview:
Parametrised successor to the fixed 16-station shared serial bus. The old bus used an externally driven one-hot mode word to choose the transmitter; this block replaces it with a round-robin arbiter over N_CH request channels. The winning channel's frame is latched, then serialised MSB-first onto a single bus line with start bit, source/destination addresses, payload, generated CRC-4 and stop bit. It sits between the station front-ends and the shared bus_show line.

Parameters:
N_CH, 16, number of requesting channels; N_CH <= 2**ADDR_W, elaboration error otherwise.
ADDR_W, 4, width of the source and destination address fields.
DATA_W, 64, payload width in bits.

Ports:
clock  in  1  single system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  N_CH  per-channel transmit request, level, held until ack
dst_addr  in  N_CH*ADDR_W  channel i destination at [i*ADDR_W +: ADDR_W]
data  in  N_CH*DATA_W  channel i payload at [i*DATA_W +: DATA_W]
ack  out  N_CH  one-cycle pulse to the served channel
bus_show  out  1  serial bus line, idles high
busy  out  1  high while a frame is on the line (START through STOP)

Behaviour:
- Reset (async assert, sync release): bus_show=1, busy=0, ack=0, state=IDLE, rr pointer=0, CRC=0.
- States: IDLE -> START -> SRC -> DST -> DATA -> CRC -> STOP -> IDLE.
- IDLE: bus_show=1. If any req is high, the arbiter grants the first requesting channel at or after the pointer, wrapping at N_CH.
  - In the grant cycle, latch src (granted index), dst_addr and data into a shift register.
  - Next state START; pointer <= grant+1 mod N_CH.
  - With no requests, stay in IDLE; the pointer is unchanged.
- Latency: req sampled high in IDLE at edge k -> start bit (0) on bus_show from edge k+1.
- Field lengths (one bit per cycle, MSB first):
  - START: 1 cycle, bus_show=0.
  - SRC: ADDR_W cycles.
  - DST: ADDR_W cycles.
  - DATA: DATA_W cycles.
  - CRC: 4 cycles.
  - STOP: 1 cycle, bus_show=1.
- Field counter: width clog2(DATA_W)+1 bits, reloaded at each field entry.
- CRC-4:
  - Polynomial x^4+x+1, constant 4'h3; init 0 at grant.
  - Covers SRC, DST and DATA bits as transmitted.
  - Per bit b: fb=crc[3]^b; crc <= {crc[2:0],1'b0} ^ (fb ? 4'h3 : 4'h0).
  - CRC field sends crc[3] first, shifting left.
- ack[grant] pulses high during the STOP cycle only.
- Request handling:
  - Fields are captured at grant; changing or dropping req/data afterwards does not alter the frame in flight.
  - A req still high after ack competes normally.
- Back-to-back frames: STOP -> IDLE costs one cycle, so there is at least one idle-high bit between frames. Maximum throughput is one frame per FRAME_LEN+1 cycles.
- dst_addr == src is legal and is transmitted unchanged. Requests on indices >= N_CH do not exist.
- Reset mid-frame: the frame is aborted at once, bus_show=1, no ack, pointer returns to 0.

Optional Feature:
- Macro SBUS_CRC_EN.
- Defined: CRC state present; FRAME_LEN = 2*ADDR_W + DATA_W + 6.
- Undefined:
  - CRC state and CRC register are removed.
  - DATA goes straight to STOP.
  - FRAME_LEN = 2*ADDR_W + DATA_W + 2.
  - All other timing is unchanged.

Decomposition:
- Package sbus_pkg:
  - state enum.
  - CRC_POLY=4'h3 and CRC_INIT=4'h0.
  - function frame_len(ADDR_W, DATA_W) honouring SBUS_CRC_EN.
- One sub-module, sbus_rr_arbiter:
  - Parametrised on N_CH.
  - Inputs: req, pointer, enable. Outputs: grant index, grant_valid.
  - Purely combinational priority rotate; the pointer register stays in the top level.

Test Plan:
- Reset: hold reset_n=0 with req all ones -> bus_show=1, busy=0, ack=0 throughout.
- Single frame, CRC enabled, defaults; req[1]=1, dst_addr ch1=2, data ch1=64'h1:
  - bus_show = 0, 0001, 0010, 63 zeros then 1, CRC 0110, then 1.
  - 78 busy cycles; ack[1] high only in the stop cycle.
- Simultaneous req[0], req[1], req[2] held until ack -> frames served in order 0, 1, 2, each separated by exactly one idle-high cycle.
- Fairness: after ch2 is served, raise req[1] and req[3] together -> ch3 is granted first, then ch1; a pointer wrap from ch15 back to ch0 is also checked.
- Reset mid-frame: drop reset_n in the DATA field -> bus_show=1 immediately, no ack. After release, req[5] alone frames with src=0101.
- SBUS_CRC_EN undefined, same stimulus as the single-frame case -> 74-cycle frame, with the stop bit directly after payload bit 0.
